// File: rtl/pc_reg.sv
// Program counter register: HOLD/RUN fetch FSM with flush/stall/branch priority select.
// Optional pending-branch buffer under `PC_BRANCH_HOLD_EN` (branch seen during IF stall is replayed on release).
module pc_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc,
  output logic        ce,
  output logic        pend_o
);

  localparam logic STOP = 1'b1;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;

`ifdef PC_BRANCH_HOLD_EN
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
`endif

  // Only the IF hold bit of the stall vector matters here.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ce_d    = ce_q;
`ifdef PC_BRANCH_HOLD_EN
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
`endif
    if (state_q == HOLD) begin
      state_d = RUN;
      ce_d    = 1'b1;
    end else begin
      if (flush) begin
        pc_d = {new_pc[31:2], 2'b00};
`ifdef PC_BRANCH_HOLD_EN
        pend_vld_d = 1'b0;
`endif
      end else if (stall[0] == STOP) begin
`ifdef PC_BRANCH_HOLD_EN
        if (branch_flag_i) begin
          pend_vld_d = 1'b1;
          pend_tgt_d = {branch_target_i[31:2], 2'b00};
        end
`endif
      end
`ifdef PC_BRANCH_HOLD_EN
      else if (pend_vld_q) begin
        pc_d       = pend_tgt_q;
        pend_vld_d = 1'b0;
      end
`endif
      else if (branch_flag_i) begin
        pc_d = {branch_target_i[31:2], 2'b00};
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      pc_q    <= 32'h0000_0000;
      ce_q    <= 1'b0;
`ifdef PC_BRANCH_HOLD_EN
      pend_vld_q <= 1'b0;
      pend_tgt_q <= 32'h0000_0000;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ce_q    <= ce_d;
`ifdef PC_BRANCH_HOLD_EN
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
`endif
    end
  end

  assign pc = pc_q;
  assign ce = ce_q;
`ifdef PC_BRANCH_HOLD_EN
  assign pend_o = pend_vld_q;
`else
  assign pend_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_reg.sv
// Bench for pc_reg: directed vector table, corner sequences, then random traffic vs a reference model.
module tb_pc_reg;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [31:0] pc;
  logic        ce;
  logic        pend_o;

  pc_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .pc(pc), .ce(ce), .pend_o(pend_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PC_BRANCH_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state: fetch running flag, pc, and the pending branch (if enabled).
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_ptgt;

  typedef struct {
    bit          r;
    bit          s;
    bit          f;
    logic [31:0] np;
    bit          b;
    logic [31:0] bt;
    logic [31:0] exp_pc;
    bit          exp_ce;
    bit          exp_pend;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] epc, input bit ece, input bit epend);
    check({tag, ".pc"}, pc, epc);
    check({tag, ".ce"}, {31'd0, ce}, {31'd0, ece});
    check({tag, ".pend"}, {31'd0, pend_o}, {31'd0, epend});
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic model_update(input bit r, input bit s, input bit f, input logic [31:0] np,
                              input bit b, input logic [31:0] bt);
    if (r) begin
      m_run = 0; m_pc = 0; m_pend = 0; m_ptgt = 0;
    end else if (!m_run) begin
      m_run = 1;
    end else if (f) begin
      m_pc = align(np); m_pend = 0;
    end else if (s) begin
      if (HOLD_EN && b) begin
        m_pend = 1; m_ptgt = align(bt);
      end
    end else if (m_pend) begin
      m_pc = m_ptgt; m_pend = 0;
    end else if (b) begin
      m_pc = align(bt);
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit f, input logic [31:0] np,
                      input bit b, input logic [31:0] bt);
    logic [4:0] hi;
    hi = 5'($urandom);
    rst = r; stall = {hi, s}; flush = f; new_pc = np;
    branch_flag_i = b; branch_target_i = bt;
    @(posedge clk);
    #1;
    model_update(r, s, f, np, b, bt);
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; new_pc = 0; branch_flag_i = 0; branch_target_i = 0;
    m_run = 0; m_pc = 0; m_pend = 0; m_ptgt = 0;

    //            r  s  f  new_pc        b  target        exp_pc        ce p
    tbl[0]  = '{1, 0, 0, 32'h0,        0, 32'h0,      32'h0,        0, 0};
    tbl[1]  = '{1, 0, 0, 32'h0,        0, 32'h0,      32'h0,        0, 0};
    tbl[2]  = '{0, 0, 0, 32'h0,        0, 32'h0,      32'h0,        1, 0};
    tbl[3]  = '{0, 0, 0, 32'h0,        0, 32'h0,      32'h4,        1, 0};
    tbl[4]  = '{0, 0, 0, 32'h0,        0, 32'h0,      32'h8,        1, 0};
    tbl[5]  = '{0, 0, 0, 32'h0,        0, 32'h0,      32'hC,        1, 0};
    tbl[6]  = '{0, 1, 1, 32'h103,      0, 32'h0,      32'h100,      1, 0};
    tbl[7]  = '{0, 0, 0, 32'h0,        1, 32'h2003,   32'h2000,     1, 0};
    tbl[8]  = '{0, 0, 0, 32'h0,        0, 32'h0,      32'h2004,     1, 0};
    tbl[9]  = '{0, 0, 1, 32'h40,       0, 32'h0,      32'h40,       1, 0};
    tbl[10] = '{0, 1, 0, 32'h0,        0, 32'h0,      32'h40,       1, 0};
    tbl[11] = '{0, 1, 0, 32'h0,        0, 32'h0,      32'h40,       1, 0};
    tbl[12] = '{0, 1, 0, 32'h0,        0, 32'h0,      32'h40,       1, 0};
    tbl[13] = '{0, 0, 0, 32'h0,        0, 32'h0,      32'h44,       1, 0};
    tbl[14] = '{0, 0, 1, 32'hFFFFFFFF, 0, 32'h0,      32'hFFFFFFFC, 1, 0};
    tbl[15] = '{0, 0, 0, 32'h0,        0, 32'h0,      32'h0,        1, 0};
    tbl[16] = '{1, 1, 1, 32'h500,      1, 32'h600,    32'h0,        0, 0};
    tbl[17] = '{0, 0, 1, 32'h700,      1, 32'h800,    32'h0,        1, 0};
    tbl[18] = '{0, 0, 0, 32'h0,        0, 32'h0,      32'h4,        1, 0};

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].np, tbl[i].b, tbl[i].bt);
      check_all($sformatf("vec%0d", i), tbl[i].exp_pc, tbl[i].exp_ce, tbl[i].exp_pend);
    end

    // Two branches during a stall: last one wins when buffered, otherwise both dropped.
    step(0, 0, 1, 32'h1000, 0, 0);  check_all("bh.base", 32'h1000, 1, 0);
    step(0, 1, 0, 0, 1, 32'h300);   check_all("bh.b1", 32'h1000, 1, HOLD_EN);
    step(0, 1, 0, 0, 1, 32'h400);   check_all("bh.b2", 32'h1000, 1, HOLD_EN);
    step(0, 0, 0, 0, 0, 0);         check_all("bh.rel", HOLD_EN ? 32'h400 : 32'h1004, 1, 0);

    // Flush during stall discards the pending branch.
    step(0, 0, 1, 32'h2000, 0, 0);  check_all("fl.base", 32'h2000, 1, 0);
    step(0, 1, 0, 0, 1, 32'h500);   check_all("fl.pend", 32'h2000, 1, HOLD_EN);
    step(0, 1, 1, 32'h8000, 0, 0);  check_all("fl.flush", 32'h8000, 1, 0);
    step(0, 0, 0, 0, 0, 0);         check_all("fl.rel", 32'h8004, 1, 0);

    // Reset with a pending branch leaves nothing behind.
    step(0, 1, 0, 0, 1, 32'h600);   check_all("rp.pend", 32'h8004, 1, HOLD_EN);
    step(1, 1, 0, 0, 1, 32'h700);   check_all("rp.rst", 32'h0, 0, 0);
    step(0, 0, 0, 0, 0, 0);         check_all("rp.hold", 32'h0, 1, 0);
    step(0, 0, 0, 0, 0, 0);         check_all("rp.run", 32'h4, 1, 0);

    for (int i = 0; i < 600; i++) begin
      bit r, s, f, b;
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 9) == 0);
      b = ($urandom_range(0, 3) == 0);
      step(r, s, f, $urandom, b, $urandom);
      check_all($sformatf("rnd%0d", i), m_pc, m_run, m_pend);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_reg.md
PC_REG -- requirements
Module: pc_reg

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset (RstEnable = 1'b1).
REQ-003 stall  input  6  controller stall vector; stall[0] = IF stage hold (Stop = 1'b1).
REQ-004 flush  input  1  exception/interrupt redirect; highest-priority non-reset event.
REQ-005 new_pc  input  32  redirect target, valid when flush = 1.
REQ-006 branch_flag_i  input  1  taken branch/jump from ID, single-cycle pulse.
REQ-007 branch_target_i  input  32  branch target, valid when branch_flag_i = 1.
REQ-008 pc  output  32  fetch address to instruction memory and to IF_ID pc_i.
REQ-009 ce  output  1  instruction-memory chip enable.
REQ-010 pend_o  output  1  a branch is held pending (debug/observability).

Function
REQ-011 The FSM SHALL have states HOLD (post-reset, ce = 0) and RUN (ce = 1), registered, not decoded combinationally.
REQ-012 HOLD SHALL move to RUN on the first clock edge with rst = 0; pc stays 32'h0000_0000 on that edge.
REQ-013 In RUN, next pc SHALL be chosen by fixed priority: flush -> new_pc; stall[0] = Stop -> pc unchanged; pend valid -> pend target; branch_flag_i -> branch_target_i; else pc + 4.
REQ-014 pc + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no carry out.
REQ-015 Every loaded target (new_pc, branch, pending) SHALL have bits [1:0] forced to 2'b00.
REQ-016 flush SHALL take effect even when stall[0] = Stop, and SHALL clear any pending branch on the same edge.
REQ-017 Branch latency: target SHALL appear on pc one cycle after the edge sampling branch_flag_i = 1 with stall[0] = NoStop.
REQ-018 flush or branch_flag_i while in HOLD SHALL be ignored; ce stays 0 in HOLD.
REQ-019 pend_o SHALL equal the internal pending-valid register.

Reset
REQ-020 On rst = 1 at a rising edge: pc = 32'h0000_0000, ce = 0, state = HOLD, pending valid = 0, pending target = 32'h0, pend_o = 0.
REQ-021 Reset SHALL override all inputs, including mid-stall and with a pending branch; no pending state survives reset.

Configuration
REQ-022 Macro PC_BRANCH_HOLD_EN SHALL gate the pending-branch buffer.
REQ-023 With PC_BRANCH_HOLD_EN defined: branch_flag_i = 1 while stall[0] = Stop SHALL latch branch_target_i (last one wins); pc loads it on the first edge with stall[0] = NoStop and no flush; pending is cleared on that edge.
REQ-024 Without PC_BRANCH_HOLD_EN: branch_flag_i during stall[0] = Stop SHALL be dropped, pend_o SHALL be tied 0, no pending registers SHALL exist, and the controller is responsible for holding the branch until release.

Verification
REQ-025 rst high 2 cycles, then low -> pc = 0, ce = 0 during reset; one edge later ce = 1, pc = 0; next edges pc = 4, 8, 12.
REQ-026 In RUN at pc = 0x100, branch_flag_i = 1, target 0x2003 -> next pc = 0x2000, then 0x2004.
REQ-027 stall[0] = 1 for 3 cycles at pc = 0x40 -> pc holds 0x40; on release pc = 0x44.
REQ-028 (PC_BRANCH_HOLD_EN) stall[0] = 1, branch to 0x300 then 0x400 during stall -> pend_o = 1, pc held; on release pc = 0x400, pend_o = 0; without macro pc = prior pc + 4.
REQ-029 Pending branch to 0x500 plus flush with new_pc = 0x8000 during stall -> pc = 0x8000, pend_o = 0; pc = 0x8004 after release.
REQ-030 pc = 0xFFFF_FFFC, no events -> pc = 0x0000_0000; rst asserted with pend_o = 1 -> pc = 0, ce = 0, pend_o = 0.
